// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared encodings for the multicycle processor control FSM: instruction
// opcodes, ALU operation codes, ALU B-operand and PC-source mux selects, the
// FSM state enum, and the packed bundle of control outputs.
// ---------------------------------------------------------------------------
package ctrl_pkg;

  // Opcode field IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation codes
  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b001;
  localparam logic [2:0] ALUOP_SUB   = 3'b010;
  localparam logic [2:0] ALUOP_ADDI  = 3'b011;
  localparam logic [2:0] ALUOP_SLTI  = 3'b100;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMM_EXEC = 4'd9,
    S_IMM_WB   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd15
  } state_e;

  // Every control output the FSM decodes, bundled so reset gating is one line.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal;
    logic       retire;
  } ctrl_t;

  // True for the seven opcodes the machine implements.
  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_SLTI) ||
           (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a classic multicycle MIPS-style datapath. Sequences each
// instruction through FETCH/DECODE and the class-specific execute, memory and
// write-back states, drives the datapath strobes and mux selects, and counts
// retired instructions.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   instr_op_i     IR[31:26], sampled only in DECODE
//   mem_ready_i    memory completes this cycle (used in FETCH/MEM_RD/MEM_WR)
//   PCWrite_o .. ALUSrcA_o   single-bit datapath strobes/selects
//   ALUSrcB_o      00 regB, 01 +4, 10 sign-ext imm, 11 imm<<2
//   PCSource_o     00 ALU, 01 ALUOut, 10 jump target
//   ALUop_o        000 R-type, 001 add, 010 sub, 011 addi, 100 slti
//   illegal_o      FSM parked in ILLEGAL
//   retire_o       one-cycle pulse in the last cycle of each instruction
//   retire_cnt_o   free-running retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  instr_op_i,
  input  logic        mem_ready_i,
  output logic        PCWrite_o,
  output logic        PCWriteCond_o,
  output logic        IorD_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        IRWrite_o,
  output logic        MemtoReg_o,
  output logic        RegDst_o,
  output logic        RegWrite_o,
  output logic        ALUSrcA_o,
  output logic [1:0]  ALUSrcB_o,
  output logic [1:0]  PCSource_o,
  output logic [2:0]  ALUop_o,
  output logic        illegal_o,
  output logic        retire_o,
  output logic [31:0] retire_cnt_o
);

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  ctrl_t       ctrl;
  ctrl_t       ctrl_out;

  // State, latched opcode and retire counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_FETCH;
      op_q         <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Next-state logic. Only DECODE looks at instr_op_i; later states steer on
  // the latched op_q so the IR may change underneath without effect.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d = instr_op_i;
        unique case (instr_op_i)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_RTYPE:         state_d = S_R_EXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_IMM_EXEC;
          OP_J:             state_d = S_JUMP;
          default:          state_d = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready_i) state_d = S_LW_WB;
      end
      S_LW_WB:    state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_R_EXEC:   state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_IMM_EXEC: state_d = S_IMM_WB;
      S_IMM_WB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode from state (and mem_ready_i in the memory-handshake states)
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC+4 are committed only in the cycle the read completes.
        ctrl.ir_write  = mem_ready_i;
        ctrl.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode is decoded.
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_LW_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.retire    = mem_ready_i;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.retire        = 1'b1;
      end
      S_IMM_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (op_q == OP_SLTI) ? ALUOP_SLTI : ALUOP_ADDI;
      end
      S_IMM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.retire    = 1'b1;
      end
      S_ILLEGAL: begin
        ctrl.illegal = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q + (ctrl.retire ? 32'd1 : 32'd0);
  end

  // Reset silences every strobe immediately, not just at the next edge.
  assign ctrl_out = rst_i ? '0 : ctrl;

  assign PCWrite_o     = ctrl_out.pc_write;
  assign PCWriteCond_o = ctrl_out.pc_write_cond;
  assign IorD_o        = ctrl_out.iord;
  assign MemRead_o     = ctrl_out.mem_read;
  assign MemWrite_o    = ctrl_out.mem_write;
  assign IRWrite_o     = ctrl_out.ir_write;
  assign MemtoReg_o    = ctrl_out.mem_to_reg;
  assign RegDst_o      = ctrl_out.reg_dst;
  assign RegWrite_o    = ctrl_out.reg_write;
  assign ALUSrcA_o     = ctrl_out.alu_src_a;
  assign ALUSrcB_o     = ctrl_out.alu_src_b;
  assign PCSource_o    = ctrl_out.pc_source;
  assign ALUop_o       = ctrl_out.alu_op;
  assign illegal_o     = ctrl_out.illegal;
  assign retire_o      = ctrl_out.retire;
  assign retire_cnt_o  = retire_cnt_q;

endmodule
